owl_pixel_packer: RTL and testbench
===================================

// Module: owl_pixel_packer
// PURPOSE
// - Downstream of the Owl camera capture control. Consumes its 48-bit beats (4 x 12-bit pixels, data_vld
//   qualified, new_frame delimited) and repacks them into a gap-free 64-bit AXI4-Stream for the frame-buffer
//   writer. Every 4 input beats become 3 output words. A FIFO absorbs output backpressure; input has no stall.
// PARAMETERS
// - FIFO_DEPTH   16   output FIFO entries (power of 2, >=4); entry = {tuser, tlast, tdata[63:0]}
// PORTS
// - sys_clk        in   1   single clock for all logic
// - sys_rst        in   1   asynchronous, active-high reset
// - new_frame      in   1   1-cycle pulse; starts a frame, aborts any frame in progress
// - pixel          in   48  packed pixel beat
// - data_vld       in   1   pixel valid this cycle
// - imageWidth     in   16  pixels per line (multiple of 4), sampled on new_frame
// - imageHeight    in   16  lines per frame, sampled on new_frame
// - m_axis_tdata   out  64  packed output word
// - m_axis_tvalid  out  1   output word valid
// - m_axis_tready  in   1   downstream accept
// - m_axis_tuser   out  1   first word of frame
// - m_axis_tlast   out  1   last word of frame
// - overflow       out  1   sticky: a word was dropped because the FIFO was full
// - frame_done     out  1   1-cycle pulse when the tlast word is accepted (tvalid & tready & tlast)
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, state IDLE, phase 0, residual 0.
// - new_frame (any state): latch total_beats = (imageWidth>>2)*imageHeight (32-bit), beat_cnt=0, phase=0,
//   residual cleared, first_pend=1, overflow cleared, state PACK. Words already in the FIFO are kept.
//   Exception: if FLUSH is active in that cycle, the flush word is written first.
// - States:
//   IDLE: data_vld ignored.
//   PACK: each data_vld beat increments beat_cnt and advances phase (mod 4).
//   FLUSH: lasts exactly 1 cycle, then DONE.
//   DONE: data_vld ignored until new_frame.
// - Packing, p = phase of the beat, R = residual register:
//   p0: R = pixel[47:0]; no write.
//   p1: write {pixel[15:0], R[47:0]}; R = pixel[47:16].
//   p2: write {pixel[31:0], R[31:0]}; R = pixel[47:32].
//   p3: write {pixel[47:0], R[15:0]}; R = 0.
//   At most one FIFO write per cycle. FIFO write latency 1 cycle; first-word-fall-through on output.
// - tuser: set on the first word written after new_frame; first_pend then clears.
// - End of frame: the beat with beat_cnt+1 == total_beats is the last beat.
//   Last beat at p3: its word carries tlast; go to DONE.
//   Otherwise: go to FLUSH. The next cycle writes R, zero-padded in the upper bits, with tlast.
//   Words per frame = ceil(3*total_beats/4).
// - total_beats == 0: no words, no tlast; state goes straight to DONE.
// - Single-beat frame: its only word (a FLUSH word) carries both tuser and tlast.
// - Aborted frame (new_frame before the last beat): no tlast is emitted for the aborted frame; R is discarded.
// - FIFO full on a write: word dropped and overflow=1 (sticky until new_frame or sys_rst).
//   Packing state advances as if the word had been written. A dropped tlast word produces no frame_done.
//   Simultaneous read and write when full is not a drop.
// - FIFO output obeys AXI rules: tdata, tuser and tlast hold stable while tvalid & ~tready.
// - sys_rst mid-frame or mid-FLUSH: immediate return to reset values; FIFO contents are lost.
// TESTING
// - 8x2 frame, beats B0..B3 back-to-back, tready=1 -> 3 words:
//   W0={B1[15:0],B0}, W1={B2[31:0],B1[47:16]}, W2={B3,B2[47:32]}; tuser on W0, tlast on W2, frame_done once.
// - 12x1 frame (3 beats) -> 3 words; W2={48'h0,B2[47:32]} with tlast, written in the FLUSH cycle after B2.
// - 4x1 frame (1 beat 48'hABC_DEF_123_456) -> 1 word 64'h0000_ABCD_EF12_3456 with tuser=1 and tlast=1.
// - tready=0 with 24 continuous beats (18 words), FIFO_DEPTH=16 -> overflow=1 on the 17th word.
//   With tready=1, exactly 16 words drain in order. Next new_frame clears overflow.
// - new_frame after 2 beats of a 16x4 frame -> 1 word from the aborted frame (no tlast).
//   The new frame's first word has tuser. Phase restarts at 0.
// - sys_rst asserted during FLUSH with words queued -> tvalid=0 next cycle, outputs 0.
//   A following 8x2 frame matches the first test.

Source files
------------

// File: rtl/owl_pixel_packer.sv
// owl_pixel_packer: repacks 48-bit beats (4 x 12-bit pixels) into a gap-free
// 64-bit AXI4-Stream. Every 4 input beats yield 3 output words; a small
// first-word-fall-through FIFO absorbs downstream backpressure.
module owl_pixel_packer #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        new_frame,
  input  logic [47:0] pixel,
  input  logic        data_vld,
  input  logic [15:0] imageWidth,
  input  logic [15:0] imageHeight,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic        frame_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_total;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [31:0] w_cnt_inc;
  logic [31:0] w_total_in;
  logic [1:0]  r_phase;
  logic [1:0]  w_phase_nxt;
  logic [47:0] r_res;
  logic [47:0] w_res_nxt;
  logic        r_first_pend;
  logic        r_overflow;
  logic        w_beat;
  logic        w_last;

  // FIFO entry = {tuser, tlast, tdata}
  logic [65:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_wr_en;
  logic [65:0] w_wr_data;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [65:0] w_head;

  assign w_total_in = 32'(imageWidth >> 2) * 32'(imageHeight);
  assign w_cnt_inc  = r_cnt + 32'd1;
  assign w_last     = (w_cnt_inc == r_total);
  // A beat coinciding with new_frame belongs to no frame and is discarded.
  assign w_beat     = (r_state == S_PACK) && data_vld && !new_frame;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && m_axis_tready;
  assign w_push  = w_wr_en && (!w_full || w_pop);
  assign w_drop  = w_wr_en && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Next-state, packing datapath and FIFO write request.
  // The FLUSH word is produced first; a concurrent new_frame then overrides
  // the packing state so the flush word and the frame restart both happen.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_res_nxt   = r_res;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    if (r_state == S_FLUSH) begin
      w_wr_en     = 1'b1;
      w_wr_data   = {r_first_pend, 1'b1, 16'h0, r_res};
      w_state_nxt = S_DONE;
    end
    if (new_frame) begin
      w_state_nxt = (w_total_in == 32'd0) ? S_DONE : S_PACK;
      w_cnt_nxt   = '0;
      w_phase_nxt = '0;
      w_res_nxt   = '0;
    end else if (w_beat) begin
      w_cnt_nxt   = w_cnt_inc;
      w_phase_nxt = r_phase + 2'd1;
      unique case (r_phase)
        2'd0: begin
          w_res_nxt = pixel;
        end
        2'd1: begin
          w_wr_en   = 1'b1;
          w_wr_data = {r_first_pend, 1'b0, pixel[15:0], r_res};
          w_res_nxt = {16'h0, pixel[47:16]};
        end
        2'd2: begin
          w_wr_en   = 1'b1;
          w_wr_data = {r_first_pend, 1'b0, pixel[31:0], r_res[31:0]};
          w_res_nxt = {32'h0, pixel[47:32]};
        end
        default: begin
          w_wr_en   = 1'b1;
          w_wr_data = {r_first_pend, w_last, pixel, r_res[15:0]};
          w_res_nxt = '0;
        end
      endcase
      if (w_last) begin
        w_state_nxt = (r_phase == 2'd3) ? S_DONE : S_FLUSH;
      end
    end
  end

  // Control and packing state registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_total      <= '0;
      r_cnt        <= '0;
      r_phase      <= '0;
      r_res        <= '0;
      r_first_pend <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_res      <= w_res_nxt;
      r_overflow <= (new_frame ? 1'b0 : r_overflow) | w_drop;
      if (new_frame) begin
        r_total      <= w_total_in;
        r_first_pend <= 1'b1;
      end else if (w_wr_en) begin
        r_first_pend <= 1'b0;
      end
    end
  end

  // FIFO pointers; reset empties the FIFO.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage, contents qualified by the pointers only.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
  end

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = m_axis_tvalid ? w_head[63:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & w_head[64];
  assign m_axis_tuser  = m_axis_tvalid & w_head[65];
  assign overflow      = r_overflow;
  assign frame_done    = w_pop & w_head[64];

endmodule

// File: tb/tb_owl_pixel_packer.sv
// Testbench for owl_pixel_packer: directed scenarios plus randomized frames,
// checked against a bit-stream reference model.
module tb_owl_pixel_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_frame;
  logic [47:0] pixel;
  logic        data_vld;
  logic [15:0] imageWidth;
  logic [15:0] imageHeight;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        overflow;
  logic        frame_done;

  always #5 clk = ~clk;

  owl_pixel_packer #(.FIFO_DEPTH(16)) dut (
    .sys_clk      (clk),
    .sys_rst      (rst),
    .new_frame    (new_frame),
    .pixel        (pixel),
    .data_vld     (data_vld),
    .imageWidth   (imageWidth),
    .imageHeight  (imageHeight),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .overflow     (overflow),
    .frame_done   (frame_done)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [65:0] gotq[$];
  logic [65:0] expq[$];
  logic [47:0] beats[$];
  int unsigned done_cnt = 0;
  bit          rnd_ready = 1'b0;
  bit          ready_force = 1'b1;

  // Downstream ready: forced level or random 3/4 duty.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    else           m_axis_tready = ready_force;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready)
      gotq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    if (frame_done) done_cnt++;
  end

  // Reference: beats form a little-endian bit stream chopped into 64-bit words.
  // A complete frame pads its tail word; an aborted one emits full words only.
  function automatic void model(input logic [47:0] b[$], input bit complete);
    logic [3071:0] s;
    int unsigned   n;
    int unsigned   nw;
    s  = '0;
    n  = b.size();
    for (int unsigned i = 0; i < n; i++) s[48*i +: 48] = b[i];
    nw = complete ? (48*n + 63) / 64 : (48*n) / 64;
    for (int unsigned k = 0; k < nw; k++)
      expq.push_back({(k == 0), (complete && k == nw - 1), s[64*k +: 64]});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int unsigned w, input int unsigned h);
    beats.delete();
    new_frame   = 1'b1;
    data_vld    = 1'b0;
    imageWidth  = 16'(w);
    imageHeight = 16'(h);
    tick();
    new_frame = 1'b0;
  endtask

  task automatic send_beat(input logic [47:0] p, input int unsigned gap);
    repeat (gap) tick();
    data_vld = 1'b1;
    pixel    = p;
    beats.push_back(p);
    tick();
    data_vld = 1'b0;
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (gotq.size() >= expq.size() && !m_axis_tvalid) break;
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic compare(input string tag, input int unsigned exp_done);
    int unsigned n;
    chk({tag, "_count"}, 66'(gotq.size()), 66'(expq.size()));
    n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int unsigned i = 0; i < n; i++) chk({tag, "_word"}, gotq[i], expq[i]);
    chk({tag, "_done"}, 66'(done_cnt), 66'(exp_done));
    gotq.delete();
    expq.delete();
    done_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; new_frame = 1'b0; pixel = '0; data_vld = 1'b0;
    imageWidth = '0; imageHeight = '0; m_axis_tready = 1'b1;
    repeat (3) tick();
    chk("rst_out", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow, frame_done, m_axis_tdata},
        '0);
    rst = 1'b0;
    tick();
    chk("idle_out", {m_axis_tvalid, overflow, m_axis_tdata}, '0);

    // 8x2 back-to-back
    start_frame(8, 2);
    for (int i = 0; i < 4; i++) send_beat(rnd48(), 0);
    model(beats, 1'b1);
    drain();
    compare("f8x2", 1);

    // 12x1: tail comes from the flush cycle
    start_frame(12, 1);
    for (int i = 0; i < 3; i++) send_beat(rnd48(), 0);
    model(beats, 1'b1);
    drain();
    compare("f12x1", 1);

    // 4x1 single beat
    start_frame(4, 1);
    send_beat(48'hABC_DEF_123_456, 0);
    drain();
    chk("f4x1_count", 66'(gotq.size()), 66'd1);
    if (gotq.size() > 0) chk("f4x1_word", gotq[0], {1'b1, 1'b1, 64'h0000_ABCD_EF12_3456});
    chk("f4x1_done", 66'(done_cnt), 66'd1);
    gotq.delete(); done_cnt = 0;

    // Overflow: 24 beats, no ready; 17th word (23rd beat) is the first drop
    ready_force = 1'b0;
    tick(); tick();
    start_frame(16, 6);
    for (int unsigned i = 1; i <= 24; i++) begin
      send_beat(rnd48(), 0);
      if (i == 22) chk("ovf_before", 66'(overflow), 66'd0);
      if (i == 23) chk("ovf_at17", 66'(overflow), 66'd1);
    end
    model(beats, 1'b1);
    void'(expq.pop_back());
    void'(expq.pop_back());
    ready_force = 1'b1;
    drain();
    chk("ovf_sticky", 66'(overflow), 66'd1);
    compare("ovf", 0);
    start_frame(8, 2);
    chk("ovf_clear", 66'(overflow), 66'd0);

    // Abort after 2 beats of 16x4, then a fresh 8x2
    start_frame(16, 4);
    send_beat(rnd48(), 0);
    send_beat(rnd48(), 0);
    model(beats, 1'b0);
    start_frame(8, 2);
    for (int i = 0; i < 4; i++) send_beat(rnd48(), 0);
    model(beats, 1'b1);
    drain();
    compare("abort", 1);

    // Reset during FLUSH with words queued
    ready_force = 1'b0;
    tick(); tick();
    start_frame(12, 1);
    for (int i = 0; i < 3; i++) send_beat(rnd48(), 0);
    rst = 1'b1;
    #1;
    chk("rst_flush_now", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow, m_axis_tdata}, '0);
    tick();
    chk("rst_flush_next", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, m_axis_tdata},
        '0);
    rst = 1'b0;
    ready_force = 1'b1;
    tick(); tick();
    chk("rst_flush_lost", 66'(gotq.size()), 66'd0);
    start_frame(8, 2);
    for (int i = 0; i < 4; i++) send_beat(rnd48(), 0);
    model(beats, 1'b1);
    drain();
    compare("post_rst", 1);

    // Randomized frames, gaps, ready and aborts; extra beats after completion must be ignored
    rnd_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      int unsigned w, h, tb, n;
      bit          ab;
      w  = 4 * $urandom_range(0, 4);
      h  = $urandom_range(0, 4);
      tb = (w / 4) * h;
      ab = (tb > 1) && ($urandom_range(0, 3) == 0);
      n  = ab ? $urandom_range(1, tb - 1) : tb;
      start_frame(w, h);
      for (int unsigned i = 0; i < n; i++) send_beat(rnd48(), $urandom_range(0, 2));
      model(beats, !ab);
      if (!ab) begin
        data_vld = 1'b1; pixel = rnd48();
        tick();
        data_vld = 1'b0;
      end
      drain();
      compare("rnd", (!ab && tb > 0) ? 1 : 0);
    end
    rnd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
